// File: rtl/path_walker_pkg.sv
// Shared node types for the path walker: grid coordinates, node-cache records,
// walker FSM state encoding and the node address helper.
package node_types;

  localparam int COORD_W = 8;
  localparam int ADDR_W  = 16;
  localparam int LEN_W   = 17;
  localparam int STEP_W  = 16;

  typedef struct packed {
    logic [COORD_W-1:0] i;
    logic [COORD_W-1:0] j;
  } coord_t;

  // One node-cache record as returned by a read.
  typedef struct packed {
    logic   visited;
    coord_t parent;
  } node_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EMIT = 3'd1,
    READ = 3'd2,
    WAIT = 3'd3,
    FIN  = 3'd4
  } state_t;

  // Row-major node address, truncated to the node-cache address width.
  function automatic logic [ADDR_W-1:0] node_addr(input coord_t c, input int unsigned grid);
    return ADDR_W'(32'(c.i) * grid + 32'(c.j));
  endfunction

endpackage

// File: rtl/path_walker_if.sv
// Node-cache read port and path-beat stream of the path walker.
// Stream is valid/ready: a beat transfers on a rising edge with out_valid && out_ready;
// while out_valid is high and out_ready low, out_i/out_j/out_last hold.
interface path_walker_if;

  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic        mem_rd_visited;
  logic [7:0]  mem_rd_parent_i;
  logic [7:0]  mem_rd_parent_j;

  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_i;
  logic [7:0]  out_j;
  logic        out_last;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_visited, mem_rd_parent_i, mem_rd_parent_j,
    output out_valid, out_i, out_j, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_visited, mem_rd_parent_i, mem_rd_parent_j,
    input  out_valid, out_i, out_j, out_last,
    output out_ready
  );

endinterface

// File: rtl/path_walker.sv
// Walks parent links from goal back to start through the node cache,
// streaming each visited coordinate (goal first, start last).
module path_walker
  import node_types::*;
#(
  parameter int GRID_SIZE = 256,
  parameter int MAX_STEPS = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       start_i,
  input  logic [7:0]       start_j,
  input  logic [7:0]       goal_i,
  input  logic [7:0]       goal_j,
  path_walker_if.master    bus,
  output logic             done,
  output logic             path_found,
  output logic [LEN_W-1:0] path_len,
  output logic             error,
  output state_t           o_dbg_state
);

  localparam logic [STEP_W-1:0] MAX_STEP_CNT = STEP_W'(MAX_STEPS);

  state_t             r_state;
  state_t             w_next;
  coord_t             r_start;
  coord_t             r_cur;
  logic [STEP_W-1:0]  r_step;
  logic [LEN_W-1:0]   r_len;
  logic               r_found;
  logic               r_err;

  node_t              w_rsp;
  logic               w_at_start;
  logic               w_walk_err;

  assign w_rsp      = {bus.mem_rd_visited, bus.mem_rd_parent_i, bus.mem_rd_parent_j};
  assign w_at_start = (r_cur == r_start);
  // Abort on a missing record, a node that names itself, or an exhausted follow budget.
  assign w_walk_err = !w_rsp.visited || (w_rsp.parent == r_cur) || (r_step == MAX_STEP_CNT);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = EMIT;
      EMIT:    if (bus.out_ready) w_next = w_at_start ? FIN : READ;
      READ:    w_next = WAIT;
      WAIT:    w_next = w_walk_err ? FIN : EMIT;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start <= '0;
      r_cur   <= '0;
      r_step  <= '0;
      r_len   <= '0;
      r_found <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_start <= '{i: start_i, j: start_j};
            r_cur   <= '{i: goal_i, j: goal_j};
            r_step  <= '0;
            r_len   <= '0;
            r_found <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (r_len != {LEN_W{1'b1}}) r_len <= r_len + 1'b1;
            if (w_at_start) r_found <= 1'b1;
          end
        end
        WAIT: begin
          if (w_walk_err) begin
            r_err <= 1'b1;
          end else begin
            r_cur  <= w_rsp.parent;
            r_step <= r_step + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    bus.out_valid   = 1'b0;
    bus.out_i       = '0;
    bus.out_j       = '0;
    bus.out_last    = 1'b0;
    done            = 1'b0;
    case (r_state)
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_i     = r_cur.i;
        bus.out_j     = r_cur.j;
        bus.out_last  = w_at_start;
      end
      READ: begin
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = node_addr(r_cur, GRID_SIZE);
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  assign path_found  = r_found;
  assign path_len    = r_len;
  assign error       = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_path_walker.sv
// Bench for path_walker: node-cache model, stream sink, and a reference walk
// computed directly from the parent-follow rules.
module tb_path_walker;
  import node_types::*;

  localparam int MAXS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_i = '0, start_j = '0, goal_i = '0, goal_j = '0;
  logic        done, path_found, error;
  logic [16:0] path_len;
  state_t      dbg_state;

  path_walker_if bus ();

  path_walker #(.GRID_SIZE(256), .MAX_STEPS(MAXS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .start_i(start_i), .start_j(start_j), .goal_i(goal_i), .goal_j(goal_j),
    .bus(bus.master),
    .done(done), .path_found(path_found), .path_len(path_len), .error(error),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- node cache model: {visited, parent_i, parent_j} ----------------
  logic [16:0] mem [int];

  function automatic int addr_of(input coord_t c);
    return int'(c.i) * 256 + int'(c.j);
  endfunction

  function automatic coord_t mk(input int i, input int j);
    coord_t c;
    c.i = 8'(i);
    c.j = 8'(j);
    return c;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      if (mem.exists(int'(bus.mem_rd_addr)))
        {bus.mem_rd_visited, bus.mem_rd_parent_i, bus.mem_rd_parent_j} <= mem[int'(bus.mem_rd_addr)];
      else
        {bus.mem_rd_visited, bus.mem_rd_parent_i, bus.mem_rd_parent_j} <= 17'h0;
    end
  end

  // ---------------- stream sink / monitor ----------------
  int          cyc = 0;
  int          ready_mode = 0;  // 0: always ready, 1: stall 4 cycles per beat, 2: random
  logic [16:0] got_q[$];
  int          rd_cnt, done_cnt, unstable_cnt, gap_bad, hs_cnt, wait_cnt;
  int          last_hs_cyc, done_cyc;
  logic        prev_stalled, prev_valid;
  logic [16:0] prev_beat;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [16:0] beat;
    if (bus.mem_rd_en) rd_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.out_valid) begin
      beat = {bus.out_last, bus.out_i, bus.out_j};
      if (prev_stalled && beat !== prev_beat) unstable_cnt++;
      if (!prev_valid && hs_cnt > 0 && (cyc - last_hs_cyc) < 3) gap_bad++;
      case (ready_mode)
        1: begin
          bus.out_ready = (wait_cnt >= 4);
          if (!bus.out_ready) wait_cnt++;
        end
        2:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b1;
      endcase
      if (bus.out_ready) begin
        got_q.push_back(beat);
        hs_cnt++;
        last_hs_cyc  = cyc;
        wait_cnt     = 0;
        prev_stalled = 1'b0;
      end else begin
        prev_stalled = 1'b1;
      end
      prev_beat = beat;
    end else begin
      prev_stalled  = 1'b0;
      bus.out_ready = (ready_mode != 1);
    end
    prev_valid = bus.out_valid;
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [16:0] exp_q[$];
  int          exp_found, exp_err, exp_reads;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    rd_cnt = 0; done_cnt = 0; unstable_cnt = 0; gap_bad = 0;
    hs_cnt = 0; wait_cnt = 0; last_hs_cyc = -1; done_cyc = -1;
    prev_stalled = 1'b0; prev_valid = 1'b0;
  endtask

  // Reference walk: follow parents from goal until start, a bad record, or the follow budget.
  task automatic model(input coord_t s, input coord_t g);
    coord_t cur;
    int     follows;
    logic [16:0] rec;
    exp_q.delete();
    exp_found = 0; exp_err = 0; exp_reads = 0;
    cur = g;
    follows = 0;
    for (int n = 0; n < 100; n++) begin
      if (cur == s) begin
        exp_q.push_back({1'b1, cur});
        exp_found = 1;
        break;
      end
      exp_q.push_back({1'b0, cur});
      exp_reads++;
      rec = mem.exists(addr_of(cur)) ? mem[addr_of(cur)] : 17'h0;
      if (!rec[16] || rec[15:0] == cur || follows == MAXS) begin
        exp_err = 1;
        break;
      end
      cur = rec[15:0];
      follows++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "/out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "/out_last"},  32'(bus.out_last), 32'd0);
    check({tag, "/out_ij"},    {16'd0, bus.out_i, bus.out_j}, 32'd0);
    check({tag, "/rd_en"},     32'(bus.mem_rd_en), 32'd0);
    check({tag, "/rd_addr"},   32'(bus.mem_rd_addr), 32'd0);
    check({tag, "/done"},      32'(done), 32'd0);
    check({tag, "/found"},     32'(path_found), 32'd0);
    check({tag, "/error"},     32'(error), 32'd0);
    check({tag, "/len"},       32'(path_len), 32'd0);
    check({tag, "/state"},     32'(dbg_state), 32'(IDLE));
  endtask

  task automatic pulse_start(input coord_t s, input coord_t g);
    @(posedge clk); #1;
    start = 1'b1;
    {start_i, start_j} = s;
    {goal_i, goal_j}   = g;
    @(posedge clk); #1;
    start = 1'b0;
    {start_i, start_j, goal_i, goal_j} = $urandom;
  endtask

  task automatic run_walk(input coord_t s, input coord_t g, input int mode, input bit poke,
                          input string tag);
    logic [31:0] got;
    model(s, g);
    ready_mode = mode;
    clear_mon();
    pulse_start(s, g);
    check({tag, "/first_valid"}, 32'(bus.out_valid), 32'd1);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (poke && c == 4) begin
        start = 1'b1;
        {start_i, start_j, goal_i, goal_j} = 32'h0102_0304;
      end
      if (poke && c == 5) start = 1'b0;
      if (done_cnt != 0) break;
    end
    check({tag, "/timeout"}, 32'(done_cnt != 0), 32'd1);
    @(posedge clk); #1;
    check({tag, "/beat_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < got_q.size()) ? {15'd0, got_q[k]} : 32'hdead_beef;
      check($sformatf("%s/beat%0d", tag, k), got, {15'd0, exp_q[k]});
    end
    check({tag, "/found"},    32'(path_found), 32'(exp_found));
    check({tag, "/error"},    32'(error), 32'(exp_err));
    check({tag, "/len"},      32'(path_len), 32'(exp_q.size()));
    check({tag, "/reads"},    32'(rd_cnt), 32'(exp_reads));
    check({tag, "/stable"},   32'(unstable_cnt), 32'd0);
    check({tag, "/gap"},      32'(gap_bad), 32'd0);
    if (exp_found != 0)
      check({tag, "/done_lat"}, 32'(done_cyc), 32'(last_hs_cyc + 1));
    repeat (2) @(posedge clk);
    #1;
    check({tag, "/done_once"}, 32'(done_cnt), 32'd1);
    check({tag, "/idle"},      32'(dbg_state), 32'(IDLE));
    check({tag, "/hold_len"},  32'(path_len), 32'(exp_q.size()));
  endtask

  task automatic set_link(input coord_t a, input coord_t p);
    mem[addr_of(a)] = {1'b1, p};
  endtask

  task automatic set_chain();
    mem.delete();
    set_link(mk(5, 5), mk(4, 5));
    set_link(mk(4, 5), mk(4, 4));
    set_link(mk(4, 4), mk(3, 4));
  endtask

  task automatic random_case(input int n);
    coord_t c[9];
    coord_t a;
    int     len, kind, idx;
    bit     dup;
    mem.delete();
    len = $urandom_range(1, 9);
    for (int k = 0; k < len; k++) begin
      do begin
        c[k] = mk($urandom_range(0, 255), $urandom_range(0, 255));
        dup = 1'b0;
        for (int m = 0; m < k; m++) if (c[m] == c[k]) dup = 1'b1;
      end while (dup);
    end
    for (int k = 0; k < len - 1; k++) set_link(c[k], c[k+1]);
    repeat (4) begin
      a = mk($urandom_range(0, 255), $urandom_range(0, 255));
      if (!mem.exists(addr_of(a))) set_link(a, mk($urandom_range(0, 255), $urandom_range(0, 255)));
    end
    kind = $urandom_range(0, 4);
    if (len > 1) begin
      idx = $urandom_range(0, len - 2);
      case (kind)
        1: mem.delete(addr_of(c[idx]));
        2: set_link(c[idx], c[idx]);
        3: set_link(c[len-2], c[0]);
        4: mem[addr_of(c[idx])] = {1'b0, c[idx+1]};
        default: ;
      endcase
    end
    run_walk(c[len-1], c[0], 2, 1'b0, $sformatf("rnd%0d_k%0d_l%0d", n, kind, len));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.out_ready = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Four-node chain, always ready, with a stray start pulse mid-walk.
    set_chain();
    run_walk(mk(3, 4), mk(5, 5), 0, 1'b1, "chain");
    check("chain/last_beat", (got_q.size() == 4) ? {15'd0, got_q[3]} : 32'hdead_beef,
          {15'd0, 1'b1, 8'd3, 8'd4});
    check("chain/len4", 32'(path_len), 32'd4);

    // start == goal: single beat, no memory traffic.
    mem.delete();
    run_walk(mk(7, 9), mk(7, 9), 0, 1'b0, "same");
    check("same/no_read", 32'(rd_cnt), 32'd0);

    // Same chain under 4-cycle backpressure on every beat.
    set_chain();
    run_walk(mk(3, 4), mk(5, 5), 1, 1'b0, "stall");

    // Missing record at (4,5).
    set_chain();
    mem.delete(addr_of(mk(4, 5)));
    run_walk(mk(3, 4), mk(5, 5), 0, 1'b0, "unvisited");
    check("unvisited/len2", 32'(path_len), 32'd2);

    // Two-node cycle exhausts the follow budget.
    mem.delete();
    set_link(mk(2, 2), mk(2, 3));
    set_link(mk(2, 3), mk(2, 2));
    run_walk(mk(0, 0), mk(2, 2), 0, 1'b0, "cycle");
    check("cycle/len9", 32'(path_len), 32'd9);

    // Clean path using exactly the full follow budget.
    mem.delete();
    for (int k = 0; k < 8; k++) set_link(mk(10 + k, 20), mk(11 + k, 20));
    run_walk(mk(18, 20), mk(10, 20), 2, 1'b0, "budget_edge");

    // Reset during the WAIT after the second beat, then a fresh walk.
    set_chain();
    ready_mode = 0;
    clear_mon();
    pulse_start(mk(3, 4), mk(5, 5));
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (got_q.size() == 2 && dbg_state == WAIT) break;
    end
    check("rstmid/reached_wait", 32'(dbg_state == WAIT), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("rstmid");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rstmid/no_done", 32'(done_cnt), 32'd0);
    check("rstmid/no_beats", 32'(got_q.size()), 32'd2);
    run_walk(mk(3, 4), mk(5, 5), 0, 1'b0, "after_rst");

    for (int n = 0; n < 24; n++) random_case(n);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/path_walker.md
PATH_WALKER -- requirements
Module: path_walker

Interface
REQ-001 Parameter GRID_SIZE, default 256, grid edge length; node address = i*GRID_SIZE + j.
REQ-002 Parameter MAX_STEPS, default 65535, parent-follow limit before loop error.
REQ-003 clk  in  1  single clock; every register updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  one-cycle request; sampled only in IDLE.
REQ-006 start_i, start_j  in  8 each  search start coordinate, sampled with start.
REQ-007 goal_i, goal_j  in  8 each  search goal coordinate, sampled with start.
REQ-008 mem_rd_en  out  1  node-cache read strobe.
REQ-009 mem_rd_addr  out  16  node-cache read address.
REQ-010 mem_rd_visited  in  1  node has a valid parent record; valid exactly 1 cycle after mem_rd_en.
REQ-011 mem_rd_parent_i, mem_rd_parent_j  in  8 each  parent coordinate; valid exactly 1 cycle after mem_rd_en.
REQ-012 out_valid  out  1  path beat valid.
REQ-013 out_ready  in  1  downstream accepts beat.
REQ-014 out_i, out_j  out  8 each  path coordinate, goal first, start last.
REQ-015 out_last  out  1  marks the start-node beat.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 path_found  out  1  last walk reached start cleanly.
REQ-018 path_len  out  17  beats emitted by last walk.
REQ-019 error  out  1  last walk aborted (unvisited node, self-parent, or MAX_STEPS).

Function
REQ-020 FSM states SHALL be IDLE, EMIT, READ, WAIT, FIN.
REQ-021 IDLE + start: latch start/goal, cur := goal, clear path_len/path_found/error and step counter, go EMIT.
REQ-022 EMIT: out_valid=1, out_i/out_j=cur, out_last=(cur==start); outputs SHALL hold stable until out_valid&&out_ready.
REQ-023 EMIT handshake: path_len += 1; if cur==start go FIN with path_found=1; else go READ.
REQ-024 READ: mem_rd_en=1 for exactly one cycle, mem_rd_addr=cur_i*GRID_SIZE+cur_j, truncated to 16 bits; go WAIT.
REQ-025 WAIT: sample memory response; if !mem_rd_visited, or parent==cur, or step counter==MAX_STEPS, set error=1 and go FIN; else cur := parent, step += 1, go EMIT.
REQ-026 FIN: done=1 for one cycle, go IDLE; path_found, path_len, error SHALL hold until next accepted start.
REQ-027 Latency: start at cycle 0 gives out_valid at cycle 1; a handshake at cycle t gives the next beat no earlier than cycle t+3; last handshake at t gives done at t+1.
REQ-028 start==goal: exactly one beat with out_last=1, path_len=1, path_found=1, and no memory read.
REQ-029 start asserted outside IDLE SHALL be ignored, with no restart or latching.
REQ-030 On error, no beat SHALL carry out_last=1, and path_found SHALL be 0.
REQ-031 mem_rd_en SHALL be 0 in every state except READ; out_valid SHALL be 0 in every state except EMIT.
REQ-032 path_len SHALL saturate at 2^17-1; the step counter is 16 bits.

Reset
REQ-033 rst SHALL force IDLE and set mem_rd_en, out_valid, out_last, done, path_found, error to 0, and path_len, mem_rd_addr, out_i, out_j to 0.
REQ-034 rst mid-walk SHALL abort immediately, with no done pulse and no further beats; the next start after reset SHALL walk normally.

Structure
REQ-035 coord_t (8-bit i/j struct), the FSM state enum, and address-calculation helpers SHALL live in the shared node_types package, alongside node_t.
REQ-036 The block SHALL be a single module with no sub-modules; the memory model and stream sink belong to the testbench only.

Verification
REQ-037 Chain (5,5)<-(4,5)<-(4,4)<-(3,4) with start=(3,4), goal=(5,5), out_ready=1 -> beats (5,5),(4,5),(4,4),(3,4), last on the 4th beat, path_len=4, path_found=1, done one cycle after the 4th handshake.
REQ-038 start=goal=(7,9) -> one beat (7,9) with out_last=1, mem_rd_en never asserted, path_len=1.
REQ-039 Same chain as REQ-037, with out_ready low for 4 cycles during each beat -> out_i/out_j/out_last stable while stalled, identical beat sequence.
REQ-040 Node (4,5) unvisited -> beats (5,5),(4,5) only, error=1, path_found=0, no out_last, done pulse.
REQ-041 Two-node cycle (2,2)<->(2,3) with MAX_STEPS=8 -> error=1 after 8 parent follows, 9 beats emitted, done pulse.
REQ-042 rst asserted during WAIT of the 2nd node, then a new start -> outputs zero the cycle after rst, and the new walk produces the full correct sequence.
